// File: rtl/prio_event_encoder.sv
// Priority event encoder: captures rising edges on N request lines into a
// pending register and hands them out one at a time as a binary index,
// held under a valid/ack handshake until the consumer accepts it.
module prio_event_encoder #(
  parameter int unsigned N         = 8,
  parameter bit          PRIO_HIGH = 1'b1,
  localparam int unsigned W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] x,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         multi,
  output logic [N-1:0] pending
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] y_d;
  logic         valid_d;
  logic         multi_d;
  logic [N-1:0] x_q;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [N-1:0] pending_d;
  logic [N-1:0] y_onehot;

  // Index of the winning set bit; the later match in scan order wins.
  function automatic logic [W-1:0] sel(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < int'(N); i++) begin
        if (v[i]) idx = W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (v[i]) idx = W'(i);
      end
    end
    return idx;
  endfunction

  // Edge detect, clear mask and capture; a set in the same cycle beats the clear.
  always_comb begin
    y_onehot  = N'(1) << y;
    rise      = x & ~x_q;
    clr       = (valid && ack) ? y_onehot : '0;
    cand      = pending & ~y_onehot;
    pending_d = (pending & ~clr) | (en ? rise : '0);
    multi_d   = en && ($countones(rise) >= 2);
  end

  // Input history, pending events and the multi-event pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      pending <= '0;
      multi   <= 1'b0;
    end else begin
      x_q     <= x;
      pending <= pending_d;
      multi   <= multi_d;
    end
  end

  // Grant FSM next-state and output values; HOLD picks only from registered pending.
  always_comb begin
    state_d = state_q;
    y_d     = y;
    valid_d = valid;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          y_d     = sel(pending);
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          if (|cand) begin
            y_d = sel(cand);
          end else begin
            y_d     = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        y_d     = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Grant FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y       <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      y       <= y_d;
      valid   <= valid_d;
    end
  end

endmodule

// File: tb/tb_prio_event_encoder.sv
// Bench for prio_event_encoder: a high- and a low-priority instance share
// stimulus; accepted grants are compared against per-instance expectation queues.
module tb_prio_event_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] x;
  logic       ack;
  logic [2:0] y_h, y_l;
  logic       valid_h, valid_l, multi_h, multi_l;
  logic [7:0] pending_h, pending_l;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_h[$];
  logic [2:0] exp_l[$];

  prio_event_encoder #(.N(8), .PRIO_HIGH(1'b1)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .ack(ack),
    .y(y_h), .valid(valid_h), .multi(multi_h), .pending(pending_h)
  );

  prio_event_encoder #(.N(8), .PRIO_HIGH(1'b0)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .ack(ack),
    .y(y_l), .valid(valid_l), .multi(multi_l), .pending(pending_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold ack until both instances are idle with nothing pending, bounded.
  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    ack  = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (!valid_h && !valid_l && pending_h == 8'h00 && pending_l == 8'h00) begin
        done = 1'b1;
        break;
      end
    end
    ack = 1'b0;
    check("drain_done", 32'(done), 32'd1);
  endtask

  // Scoreboard: each accepted grant must match the next expected index.
  always @(negedge clk) begin
    if (rst_n && valid_h && ack) begin
      check("sb_h_avail", 32'(exp_h.size() != 0), 32'd1);
      if (exp_h.size() != 0) check("grant_h", 32'(y_h), 32'(exp_h.pop_front()));
    end
    if (rst_n && valid_l && ack) begin
      check("sb_l_avail", 32'(exp_l.size() != 0), 32'd1);
      if (exp_l.size() != 0) check("grant_l", 32'(y_l), 32'(exp_l.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    x     = 8'hFF;
    ack   = 1'b0;

    // Reset with all lines high, then release: every line rises at once.
    repeat (3) step();
    check("rst_y", 32'(y_h), 32'd0);
    check("rst_valid", 32'(valid_h), 32'd0);
    check("rst_pending", 32'(pending_h), 32'h00);
    check("rst_multi", 32'(multi_h), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_multi", 32'(multi_h), 32'd1);
    check("rel_pending", 32'(pending_h), 32'hFF);
    check("rel_valid0", 32'(valid_h), 32'd0);
    step();
    check("rel_multi_pulse", 32'(multi_h), 32'd0);
    check("rel_valid1", 32'(valid_h), 32'd1);
    check("rel_y_h", 32'(y_h), 32'd7);
    check("rel_y_l", 32'(y_l), 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp_h.push_back(3'(7 - i));
      exp_l.push_back(3'(i));
    end
    x = 8'h00;
    drain(20);

    // Single event held without ack, then a one-cycle ack.
    x = 8'h04;
    exp_h.push_back(3'd2);
    exp_l.push_back(3'd2);
    step();
    check("single_pend", 32'(pending_h), 32'h04);
    check("single_valid0", 32'(valid_h), 32'd0);
    x = 8'h00;
    step();
    check("single_valid", 32'(valid_h), 32'd1);
    check("single_y", 32'(y_h), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("single_hold_v", 32'(valid_h), 32'd1);
      check("single_hold_y", 32'(y_h), 32'd2);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("single_done_v", 32'(valid_h), 32'd0);
    check("single_done_y", 32'(y_h), 32'd0);
    check("single_done_p", 32'(pending_h), 32'h00);

    // Simultaneous events with ack held: back-to-back grants.
    x   = 8'h91;
    ack = 1'b1;
    exp_h.push_back(3'd7); exp_h.push_back(3'd4); exp_h.push_back(3'd0);
    exp_l.push_back(3'd0); exp_l.push_back(3'd4); exp_l.push_back(3'd7);
    step();
    check("sim_multi", 32'(multi_h), 32'd1);
    check("sim_multi_l", 32'(multi_l), 32'd1);
    check("sim_pend", 32'(pending_h), 32'h91);
    step();
    check("sim_multi_off", 32'(multi_h), 32'd0);
    check("sim_y0_h", 32'(y_h), 32'd7);
    check("sim_y0_l", 32'(y_l), 32'd0);
    step();
    check("sim_y1_h", 32'(y_h), 32'd4);
    check("sim_y1_l", 32'(y_l), 32'd4);
    check("sim_v1", 32'(valid_h), 32'd1);
    step();
    check("sim_y2_h", 32'(y_h), 32'd0);
    check("sim_y2_l", 32'(y_l), 32'd7);
    check("sim_v2", 32'(valid_l), 32'd1);
    step();
    check("sim_end_h", 32'(valid_h), 32'd0);
    check("sim_end_l", 32'(valid_l), 32'd0);
    ack = 1'b0;
    x   = 8'h00;
    step();

    // A held level is one event; a rise while disabled is lost.
    x = 8'h01;
    exp_h.push_back(3'd0);
    exp_l.push_back(3'd0);
    drain(20);
    repeat (8) step();
    check("level_valid", 32'(valid_h), 32'd0);
    check("level_pend", 32'(pending_h), 32'h00);
    en = 1'b0;
    x  = 8'h09;
    step();
    step();
    en = 1'b1;
    repeat (3) step();
    check("en_lost_bit3", 32'(pending_h[3]), 32'd0);
    check("en_lost_valid", 32'(valid_h), 32'd0);
    x = 8'h00;
    step();

    // Re-rise coinciding with the ack: the set wins, line 5 is granted twice.
    x = 8'h20;
    exp_h.push_back(3'd5); exp_h.push_back(3'd5);
    exp_l.push_back(3'd5); exp_l.push_back(3'd5);
    step();
    check("coll_pend", 32'(pending_h), 32'h20);
    x = 8'h00;
    step();
    check("coll_valid", 32'(valid_h), 32'd1);
    check("coll_y", 32'(y_h), 32'd5);
    x   = 8'h20;
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("coll_kept", 32'(pending_h), 32'h20);
    check("coll_idle", 32'(valid_h), 32'd0);
    step();
    check("coll_regrant_v", 32'(valid_h), 32'd1);
    check("coll_regrant_y", 32'(y_h), 32'd5);
    drain(10);
    x = 8'h00;
    step();
    check("coll_clear", 32'(pending_h), 32'h00);

    // Asynchronous reset while holding a grant.
    x = 8'h02;
    step();
    x = 8'h00;
    step();
    check("midrst_valid", 32'(valid_h), 32'd1);
    check("midrst_y", 32'(y_h), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_drop_v", 32'(valid_h), 32'd0);
    check("midrst_drop_y", 32'(y_h), 32'd0);
    check("midrst_drop_p", 32'(pending_h), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("midrst_after", 32'(valid_h), 32'd0);

    check("sb_h_left", 32'(exp_h.size()), 32'd0);
    check("sb_l_left", 32'(exp_l.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
